serial_subtractor_ctrl: RTL and testbench
=========================================

# serial_subtractor_ctrl

Sequencer that performs a WIDTH-bit unsigned subtraction `a - b - bin` by time-multiplexing a single 4-bit subtract stage, one nibble per clock, LSB nibble first. The stage is a 4-bit `A - B - Bin -> Diff, Bout` slice. The borrow is chained between nibbles through an internal register. It gives wide-operand subtraction at the cost of one 4-bit slice, and uses a start/busy/done handshake toward the requesting logic.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 4; NIB = WIDTH/4
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only when not busy
- a  in  WIDTH  minuend, captured on accepted start
- b  in  WIDTH  subtrahend, captured on accepted start
- bin  in  1  borrow-in, captured on accepted start
- busy  out  1  high while nibbles are being processed
- done  out  1  single-cycle pulse: diff/bout just updated
- diff  out  WIDTH  result `(a - b - bin) mod 2^WIDTH`, registered
- bout  out  1  final borrow-out (1 ⇔ a < b + bin), registered

## Operation
- Three states: IDLE, RUN, DONE.
- IDLE: if start=1, go to RUN and load the internal registers:
  - opA ← a, opB ← b
  - borrow ← bin, idx ← 0
  - acc ← 0
- RUN, one nibble per cycle:
  - {bo, d} = opA[4·idx+3:4·idx] − opB[4·idx+3:4·idx] − borrow
  - acc[4·idx+3:4·idx] ← d; borrow ← bo; idx ← idx+1
  - after nibble NIB−1, go to DONE.
- DONE, one cycle:
  - diff ← acc, bout ← borrow, done=1
  - if start=1, go straight to RUN and capture new operands (back-to-back); otherwise go to IDLE.
- start while in RUN is ignored; the operands are not re-captured.
- a/b/bin may change freely after capture; only the captured copies are used.
- diff/bout change only on entry to DONE and hold until the next DONE. They do not glitch during RUN.
- idx width is ceil(log2(NIB)), minimum 1. Nibble subtraction uses 5-bit arithmetic; bo = bit 4.

## Timing
- Start sampled at edge k, with state IDLE or DONE:
  - busy=1 from after edge k through edge k+NIB.
  - done=1 and diff/bout valid after edge k+NIB+1, for exactly one cycle.
- Latency: NIB+1 cycles from accepting edge to done. Maximum throughput: one operation per NIB+1 cycles.
- busy=0 in IDLE and DONE. busy and done are never high together.
- Reset, asynchronous:
  - state=IDLE; busy=0, done=0, diff=0, bout=0; internal registers cleared.
  - Reset mid-RUN aborts the operation; no done is produced.
  - The first start after reset deasserts is handled normally.
- Borrow chain: the nibble-k borrow-in is the nibble-(k−1) borrow-out from the previous cycle. Nibble 0 uses the captured bin.
- Wrap-around: a result below zero wraps mod 2^WIDTH with bout=1 (unless saturation is compiled in).

## Configuration
- Macro SERIAL_SUB_SAT_EN.
- Defined: unsigned saturating subtract.
  - On entry to DONE, if the final borrow = 1, then diff ← 0 and bout ← 1.
  - Otherwise diff ← acc as normal.
- Undefined: diff ← acc always (modular result). No saturation logic is present.
- Latency and handshake are identical in both builds.

## Test plan
- WIDTH=16, a=0x0005, b=0x0003, bin=0, start for 1 cycle -> busy for 4 cycles, then done pulse with diff=0x0002, bout=0 at edge 5 after the start edge.
- a=0x1000, b=0x0001, bin=0 -> borrow ripples across three nibbles; diff=0x0FFF, bout=0.
- a=0x0002, b=0x0004, bin=0 -> diff=0xFFFE, bout=1; with SERIAL_SUB_SAT_EN: diff=0x0000, bout=1.
- a=0x0000, b=0x0000, bin=1 -> diff=0xFFFF, bout=1. Also a=0xC000, b=0x6000, bin=1 -> diff=0x5FFF, bout=0.
- Pulse start again during RUN -> ignored, the single result is correct. Hold start high in the DONE cycle with new operands a=0x0009, b=0x0005 -> the next done comes 5 cycles later with diff=0x0004, and diff holds its previous value in between.
- Assert rst for 1 cycle during the 2nd RUN cycle -> diff=0, bout=0, busy=0 immediately, no done. A following operation a=0x00FF, b=0x000F -> diff=0x00F0, bout=0.

Source files
------------

// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl
// Wide unsigned subtractor (a - b - bin) built from one 4-bit subtract slice,
// reused once per clock, least-significant nibble first. The borrow between
// nibbles is carried in a register. start/busy/done handshake toward the
// requester; diff/bout are registered and only change when a result lands.
//
// Build option: define SERIAL_SUB_SAT_EN to clamp negative results to zero
// (bout still reports the underflow). Without it the result wraps modulo
// 2^WIDTH.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one nibble subtracted per cycle, busy high
// DONE  | last nibble finished; result is published on the next edge, and a
//       | new start may be accepted on that same edge

module serial_subtractor_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;
    logic             borrow;
    logic [IDXW-1:0]  idx;

    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [4:0]       nib_res;
    logic [WIDTH-1:0] nib_ins;
    logic             accept;

    // Shared 4-bit slice: select the current nibble pair, subtract with the
    // chained borrow in 5-bit arithmetic (bit 4 is the borrow-out), and place
    // the 4-bit difference at its position within the accumulator.
    always_comb begin
        nib_a   = 4'(opa >> {idx, 2'b00});
        nib_b   = 4'(opb >> {idx, 2'b00});
        nib_res = {1'b0, nib_a} - {1'b0, nib_b} - {4'b0000, borrow};
        nib_ins = WIDTH'(nib_res[3:0]) << {idx, 2'b00};
        accept  = start && ((state == IDLE) || (state == DONE));
    end

    // Sequencer: capture on accepted start, ripple nibbles in RUN, publish in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            borrow <= 1'b0;
            idx    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
        end else begin
            done <= 1'b0;

            // Publishing the finished result does not depend on whether a new
            // operation is accepted on the same edge.
            if (state == DONE) begin
`ifdef SERIAL_SUB_SAT_EN
                diff <= borrow ? '0 : acc;
`else
                diff <= acc;
`endif
                bout <= borrow;
                done <= 1'b1;
            end

            if (accept) begin
                opa    <= a;
                opb    <= b;
                borrow <= bin;
                idx    <= '0;
                acc    <= '0;
                busy   <= 1'b1;
                state  <= RUN;
            end else if (state == RUN) begin
                // acc starts cleared, so OR-ing the nibble in is a write.
                acc    <= acc | nib_ins;
                borrow <= nib_res[4];
                idx    <= idx + 1'b1;
                if (idx == LAST_IDX) begin
                    busy  <= 1'b0;
                    state <= DONE;
                end
            end else begin
                busy  <= 1'b0;
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Bench for serial_subtractor_ctrl: directed cases plus randomized operations,
// compared against an arithmetic reference of a - b - bin.
`timescale 1ns/1ps

module tb_serial_subtractor_ctrl;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] last_diff = '0;
    logic             last_bout = 1'b0;

    serial_subtractor_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer subtraction, then the result policy.
    function automatic logic [WIDTH:0] ref_sub(input logic [WIDTH-1:0] ta,
                                               input logic [WIDTH-1:0] tb_,
                                               input logic tbin);
        int full;
        logic [WIDTH-1:0] d;
        logic bo;
        full = int'(ta) - int'(tb_) - int'(tbin);
        bo   = (full < 0);
        d    = WIDTH'(full + (1 << WIDTH));
`ifdef SERIAL_SUB_SAT_EN
        if (bo) d = '0;
`endif
        return {bo, d};
    endfunction

    // Drive a request at a negedge; returns at the negedge after the accepting edge.
    task automatic kick(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic tbin);
        start = 1'b1;
        a     = ta;
        b     = tb_;
        bin   = tbin;
        @(negedge clk);
    endtask

    // Entered at the negedge after the accepting edge. poke pulses start in
    // mid-RUN; chain requests the next operation in the DONE cycle, and
    // chained_in marks that the previous done pulse is visible on entry.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic tbin,
                          input bit poke, input bit chained_in, input bit chain,
                          input logic [WIDTH-1:0] na, input logic [WIDTH-1:0] nb, input logic nbin);
        logic [WIDTH:0] exp;
        exp   = ref_sub(ta, tb_, tbin);
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        bin   = 1'($urandom);
        for (int c = 1; c <= NIB; c++) begin
            chk("busy_run", busy, 1);
            if (!(chained_in && c == 1)) chk("done_run", done, 0);
            chk("diff_hold", diff, last_diff);
            chk("bout_hold", bout, last_bout);
            start = poke && (c == 2);
            @(negedge clk);
        end
        start = 1'b0;
        chk("busy_donestate", busy, 0);
        chk("done_early", done, 0);
        chk("diff_hold_done", diff, last_diff);
        if (chain) begin
            start = 1'b1;
            a     = na;
            b     = nb;
            bin   = nbin;
        end
        @(negedge clk);
        chk("done_pulse", done, 1);
        chk("diff", diff, exp[WIDTH-1:0]);
        chk("bout", bout, exp[WIDTH]);
        last_diff = exp[WIDTH-1:0];
        last_bout = exp[WIDTH];
        if (chain) begin
            chk("busy_chain", busy, 1);
        end else begin
            chk("busy_at_done", busy, 0);
            @(negedge clk);
            chk("done_single", done, 0);
            chk("busy_after", busy, 0);
            chk("diff_keep", diff, last_diff);
        end
    endtask

    logic [WIDTH-1:0] ca, cb, xa, xb;
    logic             cbin, xbin;
    bit               ch;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        chk("rst_bout", bout, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // Directed cases
        kick(16'h0005, 16'h0003, 1'b0); run_op(16'h0005, 16'h0003, 1'b0, 0, 0, 0, '0, '0, 0);
        kick(16'h1000, 16'h0001, 1'b0); run_op(16'h1000, 16'h0001, 1'b0, 0, 0, 0, '0, '0, 0);
        kick(16'h0002, 16'h0004, 1'b0); run_op(16'h0002, 16'h0004, 1'b0, 0, 0, 0, '0, '0, 0);
        kick(16'h0000, 16'h0000, 1'b1); run_op(16'h0000, 16'h0000, 1'b1, 0, 0, 0, '0, '0, 0);
        kick(16'hC000, 16'h6000, 1'b1); run_op(16'hC000, 16'h6000, 1'b1, 0, 0, 0, '0, '0, 0);
        // Start pulse in RUN is ignored; then back-to-back with 9 - 5
        kick(16'h1234, 16'h0234, 1'b0); run_op(16'h1234, 16'h0234, 1'b0, 1, 0, 1, 16'h0009, 16'h0005, 1'b0);
        run_op(16'h0009, 16'h0005, 1'b0, 0, 1, 0, '0, '0, 0);

        // Reset during the second RUN cycle aborts without a done
        kick(16'h4321, 16'h1111, 1'b0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_diff", diff, 0);
        chk("abort_bout", bout, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        last_diff = '0;
        last_bout = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < NIB + 3; c++) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
            chk("abort_idle", busy, 0);
        end
        kick(16'h00FF, 16'h000F, 1'b0); run_op(16'h00FF, 16'h000F, 1'b0, 0, 0, 0, '0, '0, 0);

        // Randomized sequence, mixing isolated and back-to-back operations
        ca   = WIDTH'($urandom);
        cb   = WIDTH'($urandom);
        cbin = 1'($urandom);
        kick(ca, cb, cbin);
        ch = 0;
        for (int i = 0; i < 30; i++) begin
            bit last_it;
            bit this_ch;
            last_it = (i == 29);
            xa   = WIDTH'($urandom);
            xb   = ($urandom_range(0, 3) == 0) ? xa : WIDTH'($urandom);
            xbin = 1'($urandom);
            this_ch = !last_it && ($urandom_range(0, 1) == 1);
            run_op(ca, cb, cbin, ($urandom_range(0, 2) == 0), ch, this_ch, xa, xb, xbin);
            if (!last_it && !this_ch) kick(xa, xb, xbin);
            ch   = this_ch;
            ca   = xa;
            cb   = xb;
            cbin = xbin;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
